bcd_clock: RTL and testbench
============================

// Module: bcd_clock
// PURPOSE
//   Free-running single-digit decimal counter (0..9, wrap) driving one 7-segment display.
//   A prescaler divides the system clock into a count tick; each tick advances the BCD digit.
//   Output is the segment pattern of the current digit, for direct connection to a
//   common-anode display (active-low segments).
// PARAMETERS
//   DIV        50_000_000  clk cycles per digit increment (>=1); 1 Hz at 50 MHz
//   ACTIVE_LOW 1           1: segment lit = 0 (common anode); 0: all seg bits inverted
// PORTS
//   clk      in   1    system clock, all state updates on rising edge
//   rst      in   1    synchronous, active-high reset
//   enable   in   1    1: prescaler and digit run; 0: hold all state
//   seg_out  out  [0:6] segments a..g, seg_out[0]=a ... seg_out[6]=g
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst), sampled on rising clk edge.
//   - State: prescaler count pre (0..DIV-1, width $clog2(DIV) min 1), digit (4-bit BCD, 0..9).
//   - rst=1 at an edge: pre<=0, digit<=0; overrides enable. seg_out shows "0" the next cycle.
//   - enable=0 (rst=0): pre and digit hold; seg_out steady.
//   - enable=1 (rst=0): if pre==DIV-1 then pre<=0 and digit advances, else pre<=pre+1.
//   - Digit advance: 0->1->...->9->0 (wrap at 9). Values 10..15 unreachable; if ever present,
//     next advance loads 0.
//   - DIV=1: digit advances on every enabled edge.
//   - Latency: first increment DIV enabled edges after rst deasserts; thereafter every DIV
//     enabled edges. Disabled cycles do not count and do not reset pre.
//   - seg_out is a combinational decode of the digit register (no extra pipeline stage);
//     it changes in the same cycle digit updates, glitch-free w.r.t. clk.
//   - Decode, ACTIVE_LOW=1, printed seg_out[0:6] (a..g):
//       0 0000001  1 1001111  2 0010010  3 0000110  4 1001100
//       5 0100100  6 0100000  7 0001111  8 0000000  9 0000100
//       digit 10..15: 1111111 (blank)
//   - ACTIVE_LOW=0: bitwise inverse of the above table.
//   - rst asserted mid-count: next edge returns to digit 0, pre 0, regardless of enable.
// TESTING  (DIV=5, ACTIVE_LOW=1, 20 ns clk period)
//   - rst=1 for 3 edges, enable=1 -> seg_out=0000001 during and right after reset.
//   - Release rst, enable=1 -> seg_out 0000001 for 5 edges, then 1001111 (1); 0010010 (2)
//     5 edges later.
//   - Run 50 enabled edges from reset -> full sequence 0..9 observed, back to 0000001 at
//     edge 50.
//   - At digit 3, drop enable for 7 edges -> seg_out stays 0000110; on re-enable the
//     remaining prescaler count completes before 4 (1001100).
//   - Assert rst for 1 edge while digit=7, enable=1 -> next cycle seg_out=0000001; next
//     increment 5 edges after release.
//   - DIV=1 build: digit advances every edge; 10 edges after reset shows 0000001 again.

Source files
------------

// File: rtl/bcd_clock.sv
//==============================================================================
// Module      : bcd_clock
// Description : Prescaled single-digit BCD counter (0..9, wrapping) with a
//               7-segment decode of the current digit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_clock #(
    parameter int DIV        = 50_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [0:6] seg_out
);

    localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [3:0]       digit_q;
    logic [3:0]       digit_d;
    logic [0:6]       seg_al;

    always_comb begin
        pre_d   = pre_q;
        digit_d = digit_q;
        if (enable) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                // Out-of-range codes fall back to 0 on the next advance.
                digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            digit_q <= 4'd0;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
        end
    end

    // Patterns are written a..g left to right, lit segment = 0.
    always_comb begin
        seg_al = 7'b1111111;
        case (digit_q)
            4'd0:    seg_al = 7'b0000001;
            4'd1:    seg_al = 7'b1001111;
            4'd2:    seg_al = 7'b0010010;
            4'd3:    seg_al = 7'b0000110;
            4'd4:    seg_al = 7'b1001100;
            4'd5:    seg_al = 7'b0100100;
            4'd6:    seg_al = 7'b0100000;
            4'd7:    seg_al = 7'b0001111;
            4'd8:    seg_al = 7'b0000000;
            4'd9:    seg_al = 7'b0000100;
            default: seg_al = 7'b1111111;
        endcase
    end

    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign seg_out = seg_al;
        end else begin : g_active_high
            assign seg_out = ~seg_al;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bcd_clock.sv
//==============================================================================
// Module      : tb_bcd_clock
// Description : Scoreboard bench for bcd_clock (DIV=5 both polarities, DIV=1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_clock;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [0:6] seg5;
    logic [0:6] seg5_inv;
    logic [0:6] seg1;

    bcd_clock #(.DIV(5), .ACTIVE_LOW(1'b1)) u_dut5 (
        .clk(clk), .rst(rst), .enable(enable), .seg_out(seg5)
    );
    bcd_clock #(.DIV(5), .ACTIVE_LOW(1'b0)) u_dut5_inv (
        .clk(clk), .rst(rst), .enable(enable), .seg_out(seg5_inv)
    );
    bcd_clock #(.DIV(1), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .seg_out(seg1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [6:0] s5;
        logic [6:0] s5i;
        logic [6:0] s1;
    } exp_t;

    exp_t sb[$];
    int   cnt;
    int   n_vec;
    int   n_err;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // One rising edge: the reference counts enabled edges since reset and
    // derives each digit from that count, then queues the expected patterns.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (rst)         cnt = 0;
        else if (enable) cnt++;
        e.s5  = seg_of((cnt / 5) % 10);
        e.s5i = ~seg_of((cnt / 5) % 10);
        e.s1  = seg_of(cnt % 10);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_vec += 3;
            if (seg5 !== e.s5) begin
                n_err++; $display("FAIL reset_div5 edge%0d got=%b exp=%b", i, seg5, e.s5);
            end
            if (seg5_inv !== e.s5i) begin
                n_err++; $display("FAIL reset_inv edge%0d got=%b exp=%b", i, seg5_inv, e.s5i);
            end
            if (seg1 !== e.s1) begin
                n_err++; $display("FAIL reset_div1 edge%0d got=%b exp=%b", i, seg1, e.s1);
            end
        end
        n_vec++;
        if (seg5 !== 7'b0000001) begin
            n_err++; $display("FAIL reset_zero got=%b exp=0000001", seg5);
        end
    endtask

    task automatic test_count();
        exp_t e;
        rst = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            e = sb.pop_front();
            n_vec += 3;
            if (seg5 !== e.s5) begin
                n_err++; $display("FAIL count_div5 edge%0d got=%b exp=%b", i, seg5, e.s5);
            end
            if (seg5_inv !== e.s5i) begin
                n_err++; $display("FAIL count_inv edge%0d got=%b exp=%b", i, seg5_inv, e.s5i);
            end
            if (seg1 !== e.s1) begin
                n_err++; $display("FAIL count_div1 edge%0d got=%b exp=%b", i, seg1, e.s1);
            end
            if (i == 4 || i == 5 || i == 10 || i == 50) begin
                n_vec++;
                if (seg5 !== ((i == 5) ? 7'b1001111 : (i == 10) ? 7'b0010010 : 7'b0000001)) begin
                    n_err++; $display("FAIL count_boundary edge%0d got=%b", i, seg5);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        rst = 1'b1; enable = 1'b1;
        tick(); void'(sb.pop_front());
        rst = 1'b0;
        // 17 enabled edges: digit 3 with the prescaler two steps in.
        for (int i = 0; i < 17; i++) begin
            tick(); void'(sb.pop_front());
        end
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            e = sb.pop_front();
            n_vec += 2;
            if (seg5 !== 7'b0000110 || seg5 !== e.s5) begin
                n_err++; $display("FAIL hold_div5 edge%0d got=%b exp=0000110", i, seg5);
            end
            if (seg1 !== e.s1) begin
                n_err++; $display("FAIL hold_div1 edge%0d got=%b exp=%b", i, seg1, e.s1);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if (seg5 !== ((i == 3) ? 7'b1001100 : 7'b0000110) || seg5 !== e.s5) begin
                n_err++; $display("FAIL resume_div5 edge%0d got=%b exp=%b", i, seg5, e.s5);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rst = 1'b1; enable = 1'b1;
        tick(); void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick(); void'(sb.pop_front());
        end
        n_vec++;
        if (seg5 !== 7'b0001111) begin
            n_err++; $display("FAIL mid_at7 got=%b exp=0001111", seg5);
        end
        rst = 1'b1;
        tick(); void'(sb.pop_front());
        rst = 1'b0;
        n_vec++;
        if (seg5 !== 7'b0000001) begin
            n_err++; $display("FAIL mid_reset got=%b exp=0000001", seg5);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = sb.pop_front();
            n_vec += 2;
            if (seg5 !== e.s5) begin
                n_err++; $display("FAIL mid_restart edge%0d got=%b exp=%b", i, seg5, e.s5);
            end
            if (seg1 !== e.s1) begin
                n_err++; $display("FAIL mid_div1 edge%0d got=%b exp=%b", i, seg1, e.s1);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 60) == 0);
            tick();
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL random_queue_empty edge%0d", i);
            end else begin
                e = sb.pop_front();
                n_vec += 3;
                if (seg5 !== e.s5) begin
                    n_err++; $display("FAIL random_div5 edge%0d got=%b exp=%b", i, seg5, e.s5);
                end
                if (seg5_inv !== e.s5i) begin
                    n_err++; $display("FAIL random_inv edge%0d got=%b exp=%b", i, seg5_inv, e.s5i);
                end
                if (seg1 !== e.s1) begin
                    n_err++; $display("FAIL random_div1 edge%0d got=%b exp=%b", i, seg1, e.s1);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        cnt    = 0;
        n_vec  = 0;
        n_err  = 0;
        @(negedge clk);
        test_reset();
        test_count();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
